// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared sizing and elaboration-time KMP transition helpers
package seq_det_pkg;

    localparam int MAX_SEQ_LEN = 16;

    function automatic int state_w(input int len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of an n-bit
    // string; the string is the pattern itself (full) or prefix(k) followed by b.
    function automatic int longest_border(
        input logic [15:0] seq,
        input int          len,
        input int          n,
        input int          k,
        input logic        b,
        input logic        full
    );
        int   best;
        int   si;
        logic ok;
        logic sb;
        best = 0;
        for (int j = n - 1; j > 0; j--) begin
            if (best == 0) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    si = n - j + i;
                    sb = (full || si < k) ? seq[len-1-si] : b;
                    if (seq[len-1-i] != sb) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    function automatic int kmp_next(
        input logic [15:0] seq,
        input int          len,
        input logic        overlap,
        input int          k,
        input logic        b
    );
        int nxt;
        if (k < len - 1 && b == seq[len-1-k]) begin
            nxt = k + 1;
        end else if (k == len - 1 && b == seq[0]) begin
            nxt = overlap ? longest_border(seq, len, len, len, 1'b0, 1'b1) : 0;
        end else begin
            nxt = longest_border(seq, len, k + 1, k, b, 1'b0);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter with synchronous clear
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_match_counter: CNT_W must be at least 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parameterised serial pattern detector (Mealy, KMP transitions)
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 SEQ_LEN = 3,
    parameter logic [SEQ_LEN-1:0] SEQ     = 3'b101,
    parameter logic               OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic             clear,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_count
);

    if (SEQ_LEN < 2 || SEQ_LEN > MAX_SEQ_LEN || CNT_W < 1) begin : g_bad_params
        $error("seq_detector_param: SEQ_LEN must be 2..16 and CNT_W >= 1");
    end

    localparam int               SW       = state_w(SEQ_LEN);
    localparam int               NS       = 2 ** SW;
    localparam logic [15:0]      SEQ_EXT  = 16'(SEQ);
    localparam logic [SW-1:0]    S_LAST   = SW'(SEQ_LEN - 1);
    localparam logic             LAST_BIT = SEQ_EXT[0];

    logic [SW-1:0] r_state;
    logic          r_z_q;
    logic [SW-1:0] w_tbl0 [0:NS-1];
    logic [SW-1:0] w_tbl1 [0:NS-1];
    logic [SW-1:0] w_next;
    logic          w_z;
    logic          w_state_ok;

    // Encodings beyond SEQ_LEN-1 are unreachable; their table rows fall back to S0.
    for (genvar k = 0; k < NS; k++) begin : g_tbl
        if (k < SEQ_LEN) begin : g_live
            localparam int N0 = kmp_next(SEQ_EXT, SEQ_LEN, OVERLAP, k, 1'b0);
            localparam int N1 = kmp_next(SEQ_EXT, SEQ_LEN, OVERLAP, k, 1'b1);
            assign w_tbl0[k] = SW'(N0);
            assign w_tbl1[k] = SW'(N1);
        end else begin : g_dead
            assign w_tbl0[k] = '0;
            assign w_tbl1[k] = '0;
        end
    end

    assign w_state_ok = (r_state <= S_LAST);
    assign w_next     = x ? w_tbl1[r_state] : w_tbl0[r_state];
    assign w_z        = !rst && in_valid && (r_state == S_LAST) && (x == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_z_q   <= 1'b0;
        end else begin
            r_z_q <= w_z;
            if (in_valid) begin
                r_state <= w_next;
            end else if (!w_state_ok) begin
                r_state <= '0;
            end
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (w_z),
        .count (match_count)
    );

    assign z   = w_z;
    assign z_q = r_z_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench driving five detector configurations in lockstep
module tb_seq_detector_param;

    localparam int          ND        = 5;
    localparam int          P_LEN [ND] = '{3, 3, 4, 3, 6};
    localparam logic [15:0] P_SEQ [ND] = '{16'b101, 16'b101, 16'b1101, 16'b101, 16'b110110};
    localparam int          P_OV  [ND] = '{1, 0, 1, 1, 0};
    localparam int          P_CW  [ND] = '{8, 8, 8, 2, 3};

    typedef struct packed {
        logic            chk;
        logic [ND-1:0]   z;
        logic [ND-1:0]   zq;
        logic [ND-1:0][7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic x;
    logic clear;

    logic [ND-1:0] dz;
    logic [ND-1:0] dzq;
    logic [7:0]    dcnt [ND];
    logic [7:0]    c0, c1, c2;
    logic [1:0]    c3;
    logic [2:0]    c4;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb [$];
    exp_t me;

    bit   m_hist [ND][$];
    int   m_zq   [ND];
    int   m_cnt  [ND];
    bit   m_init = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
        .z(dz[0]), .z_q(dzq[0]), .match_count(c0));

    seq_detector_param #(.OVERLAP(1'b0)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
        .z(dz[1]), .z_q(dzq[1]), .match_count(c1));

    seq_detector_param #(.SEQ_LEN(4), .SEQ(4'b1101), .OVERLAP(1'b1)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
        .z(dz[2]), .z_q(dzq[2]), .match_count(c2));

    seq_detector_param #(.CNT_W(2)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
        .z(dz[3]), .z_q(dzq[3]), .match_count(c3));

    seq_detector_param #(.SEQ_LEN(6), .SEQ(6'b110110), .OVERLAP(1'b0), .CNT_W(3)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
        .z(dz[4]), .z_q(dzq[4]), .match_count(c4));

    assign dcnt[0] = c0;
    assign dcnt[1] = c1;
    assign dcnt[2] = c2;
    assign dcnt[3] = 8'(c3);
    assign dcnt[4] = 8'(c4);

    // Reference: a match is the last SEQ_LEN accepted bits (since reset, or
    // since the previous match when non-overlapping) spelling the pattern.
    function automatic bit model_z(input int d, input bit r, input bit v, input bit xx);
        bit s [$];
        int len;
        bit hit;
        len = P_LEN[d];
        s = m_hist[d];
        s.push_back(xx);
        hit = !r && v && (s.size() >= len);
        if (hit) begin
            for (int i = 0; i < len; i++) begin
                if (s[s.size() - len + i] != P_SEQ[d][len-1-i]) hit = 1'b0;
            end
        end
        return hit;
    endfunction

    task automatic step(input bit r, input bit v, input bit xx, input bit c);
        exp_t e;
        bit   zx;
        int   cmax;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; x = xx; clear = c;
        e = '0;
        e.chk = m_init;
        for (int d = 0; d < ND; d++) begin
            zx = model_z(d, r, v, xx);
            e.z[d]   = zx;
            e.zq[d]  = m_zq[d][0];
            e.cnt[d] = 8'(m_cnt[d]);
            cmax = (1 << P_CW[d]) - 1;
            if (r) begin
                m_hist[d].delete();
                m_zq[d]  = 0;
                m_cnt[d] = 0;
            end else begin
                m_zq[d] = int'(zx);
                if (c) m_cnt[d] = 0;
                else if (zx && m_cnt[d] < cmax) m_cnt[d] = m_cnt[d] + 1;
                if (v) m_hist[d].push_back(xx);
                if (zx && P_OV[d] == 0) m_hist[d].delete();
                while (m_hist[d].size() > 16) void'(m_hist[d].pop_front());
            end
        end
        if (r) m_init = 1'b1;
        sb.push_back(e);
    endtask

    task automatic send(input logic [15:0] bv, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bv[i], 1'b0);
    endtask

    task automatic chk_cnt(input int d, input int exp_v, input string name);
        checks++;
        if (int'(dcnt[d]) != exp_v) begin
            failures++;
            $display("FAIL %s dut%0d match_count got=%0d exp=%0d", name, d, dcnt[d], exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (dz[d] !== me.z[d]) begin
                    failures++;
                    $display("FAIL z dut%0d t=%0t got=%b exp=%b", d, $time, dz[d], me.z[d]);
                end
                if (me.chk) begin
                    checks += 2;
                    if (dzq[d] !== me.zq[d]) begin
                        failures++;
                        $display("FAIL z_q dut%0d t=%0t got=%b exp=%b", d, $time, dzq[d], me.zq[d]);
                    end
                    if (dcnt[d] !== me.cnt[d]) begin
                        failures++;
                        $display("FAIL count dut%0d t=%0t got=%0d exp=%0d", d, $time, dcnt[d], me.cnt[d]);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = 1'b0; clear = 1'b0;
        for (int d = 0; d < ND; d++) begin
            m_zq[d] = 0;
            m_cnt[d] = 0;
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk_cnt(0, 0, "reset");

        send(16'b10101, 5);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk_cnt(0, 2, "ovl_101");
        chk_cnt(1, 1, "novl_101");

        step(1, 0, 0, 0);
        send(16'b1101101, 7);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk_cnt(2, 2, "ovl_1101");
        step(1, 0, 0, 0);
        send(16'b11101, 5);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk_cnt(2, 1, "fail_path_1101");

        step(1, 0, 0, 0);
        send(16'b10, 2);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        send(16'b1, 1);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk_cnt(0, 1, "valid_gap");

        step(1, 0, 0, 0);
        send(16'b10101010101, 11);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk_cnt(3, 3, "saturate");
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk_cnt(3, 0, "clear_vs_match");

        step(1, 0, 0, 0);
        send(16'b10, 2);
        step(1, 0, 0, 0);
        send(16'b101, 3);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk_cnt(0, 1, "reset_midmatch");

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(199) == 0, $urandom_range(3) != 0,
                 1'($urandom_range(1)), $urandom_range(49) == 0);
        end

        step(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 3, pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter SEQ, default 3'b101, target pattern; SEQ[SEQ_LEN-1] is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, match-counter width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, x is sampled only when high.
REQ-008 SHALL have port x, input, 1, serial data bit.
REQ-009 SHALL have port clear, input, 1, synchronous clear of the match counter.
REQ-010 SHALL have port z, output, 1, Mealy match flag, combinational from state, x and in_valid.
REQ-011 SHALL have port z_q, output, 1, z registered (one-cycle-delayed copy).
REQ-012 SHALL have port match_count, output, CNT_W, saturating count of accepted matches.

Function
REQ-013 SHALL hold state S0..S(SEQ_LEN-1), Sk = the longest pattern prefix matched so far has length k.
REQ-014 SHALL, on an accepted bit (in_valid=1) in Sk with x = next pattern bit and k<SEQ_LEN-1, move to S(k+1).
REQ-015 SHALL, on a mismatch, move to S(f), f = longest proper pattern prefix that is a suffix of the received string (KMP failure transition, x included).
REQ-016 SHALL assert z=1 exactly when state=S(SEQ_LEN-1), in_valid=1 and x=SEQ[0]; otherwise z=0.
REQ-017 SHALL, on a match with OVERLAP=1, move to the failure state of the full pattern (longest proper prefix equal to a suffix of SEQ).
REQ-018 SHALL, on a match with OVERLAP=0, move to S0.
REQ-019 SHALL hold state and force z=0 whenever in_valid=0.
REQ-020 SHALL register z into z_q every cycle (latency 1), independent of in_valid.
REQ-021 SHALL increment match_count by 1 on each cycle with z=1, saturating at 2^CNT_W-1 (no wrap).
REQ-022 SHALL, when clear=1, load match_count with 0 on that edge; clear takes priority over a simultaneous match; state, z and z_q are unaffected.
REQ-023 SHALL force z=0 while rst=1.
REQ-024 SHALL evaluate unreachable state encodings to S0 with z=0.

Reset
REQ-025 SHALL, on a clock edge with rst=1, set state=S0, z_q=0 and match_count=0, overriding in_valid, x and clear.
REQ-026 SHALL discard any partial match in progress at reset; detection restarts from S0 on the first edge after rst falls.

Structure
REQ-027 SHALL place the state-width calculation ($clog2(SEQ_LEN)) and the constant function computing the KMP transition table from SEQ/SEQ_LEN in shared package seq_det_pkg; the table is fixed at elaboration with no runtime logic.
REQ-028 SHALL implement the saturating counter with clear as sub-module seq_match_counter (parameter CNT_W; ports clk, rst, clear, inc, count).
REQ-029 SHALL reject SEQ_LEN outside 2..16 or CNT_W<1 at elaboration.

Verification
REQ-030 SHALL cover defaults (101, OVERLAP=1), x=1,0,1,0,1 with in_valid=1 -> z=1 on the 3rd and 5th bits; match_count=2; z_q follows one cycle later.
REQ-031 SHALL cover 101 with OVERLAP=0, same stimulus -> z=1 on the 3rd bit only; match_count=1.
REQ-032 SHALL cover SEQ_LEN=4, SEQ=1101, OVERLAP=1, x=1,1,0,1,1,0,1 -> z=1 on bits 4 and 7; x=1,1,1,0,1 -> z=1 on bit 5 (failure path S2 on 1 -> S2).
REQ-033 SHALL cover 101 with in_valid=0 for 3 cycles between 1,0 and 1 (x toggling during the gap) -> z=0 in the gap; z=1 on the final accepted 1.
REQ-034 SHALL cover CNT_W=2 with 5 matches -> match_count 1,2,3,3,3; clear asserted together with a 6th match -> count=0.
REQ-035 SHALL cover rst for one cycle after 1,0 of 101, then 1 -> z=0; a following 0,1 -> z=1; match_count=1.
